// File: rtl/local_bus_pkg.sv
// Shared definitions for the 68030 local bus cycle controller.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package local_bus_pkg;

  // All CPU-side strobes are active-low
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXTWAIT,
    ST_ACK,
    ST_BERR
  } state_t;

  // Port size codes as stored in the region table
  localparam logic [1:0] PORT_32 = 2'd0;
  localparam logic [1:0] PORT_16 = 2'd1;
  localparam logic [1:0] PORT_8  = 2'd2;

  // {DSACK1,DSACK0} encodings
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // Unused port code 3 is treated as a 32-bit port
  function automatic logic [1:0] dsack_for_port(input logic [1:0] port);
    case (port)
      PORT_16: dsack_for_port = DSACK_16;
      PORT_8:  dsack_for_port = DSACK_8;
      default: dsack_for_port = DSACK_32;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_select.sv
// Byte-lane strobe decode from SIZ, A[1:0] and DS.
// Latency: combinational.
// Backpressure: none; all lanes inactive while DS is negated.
module byte_lane_select
  import local_bus_pkg::*;
(
  input  logic [1:0] siz,
  input  logic [1:0] addr_lo,
  input  logic       ds,
  output logic [3:0] byte_select
);

  logic [3:0] lane_mask;

  // Left-justified lane pattern for the transfer size before address shift
  always_comb begin
    case (siz)
      2'b01:   lane_mask = 4'b1000;
      2'b10:   lane_mask = 4'b1100;
      2'b11:   lane_mask = 4'b1110;
      default: lane_mask = 4'b1111;
    endcase
  end

  assign byte_select = (ds == ACTIVE) ? ~(lane_mask >> addr_lo) : 4'hF;

endmodule

// File: rtl/local_bus_controller.sv
// 68030 local bus cycle controller: region decode, wait states, DSACK/BERR.
// Latency: DSACK REGION_WAIT+1 edges after AS sampled (plus ext_ack wait); BERR next edge if unmapped.
// Backpressure: holds DSACK/BERR until AS negates; AS negated early aborts the cycle.
module local_bus_controller
  import local_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {32'h8000_0000, 32'h7000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {4'd0, 4'd3, 4'd0, 4'd2},
  parameter logic [NUM_REGIONS*2-1:0] REGION_PORT = {2'd0, 2'd2, 2'd0, 2'd0},
  parameter logic [NUM_REGIONS-1:0]   REGION_EXT  = 4'b1000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_as,
  input  logic                   cpu_ds,
  input  logic [1:0]             cpu_siz,
  input  logic [ADDR_WIDTH-1:0]  cpu_address,
  input  logic                   ext_ack,
  output logic [NUM_REGIONS-1:0] region_select,
  output logic [3:0]             byte_select,
  output logic [1:0]             cpu_dsack,
  output logic                   cpu_berr,
  output logic                   busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value on the edge before it reaches TIMEOUT_CYCLES
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_REGIONS-1:0] hit;
  logic                   any_hit;
  logic [NUM_REGIONS-1:0] hit_sel;
  logic [3:0]             hit_wait;
  logic [1:0]             hit_port;
  logic                   hit_ext;
  logic [3:0]             lane_sel;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      port_q;
  logic            ext_q;

  // Per-region address match
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    assign hit[g] = (cpu_address & REGION_MASK[g*ADDR_WIDTH +: ADDR_WIDTH]) ==
                    REGION_BASE[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign any_hit = |hit;

  // Priority select of the winning region's attributes; lowest index wins
  always_comb begin
    hit_sel  = '1;
    hit_wait = '0;
    hit_port = PORT_32;
    hit_ext  = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_sel    = '1;
        hit_sel[i] = ACTIVE;
        hit_wait   = REGION_WAIT[i*4 +: 4];
        hit_port   = REGION_PORT[i*2 +: 2];
        hit_ext    = REGION_EXT[i];
      end
    end
  end

  byte_lane_select u_byte_lane_select (
    .siz         (cpu_siz),
    .addr_lo     (cpu_address[1:0]),
    .ds          (cpu_ds),
    .byte_select (lane_sel)
  );

  // Cycle state machine with all bus outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      to_cnt        <= '0;
      port_q        <= PORT_32;
      ext_q         <= 1'b0;
      region_select <= '1;
      byte_select   <= 4'hF;
      cpu_dsack     <= DSACK_NONE;
      cpu_berr      <= INACTIVE;
      busy          <= 1'b0;
    end else if (state != ST_IDLE && cpu_as == INACTIVE) begin
      // AS negated: either normal termination or an abort, outputs drop together
      state         <= ST_IDLE;
      region_select <= '1;
      byte_select   <= 4'hF;
      cpu_dsack     <= DSACK_NONE;
      cpu_berr      <= INACTIVE;
      busy          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (cpu_as == ACTIVE && any_hit) begin
            state         <= ST_WAIT;
            wait_cnt      <= hit_wait;
            port_q        <= hit_port;
            ext_q         <= hit_ext;
            region_select <= hit_sel;
            byte_select   <= lane_sel;
            busy          <= 1'b1;
          end else if (cpu_as == ACTIVE) begin
            state    <= ST_BERR;
            cpu_berr <= ACTIVE;
            busy     <= 1'b1;
          end
        end
        ST_WAIT, ST_EXTWAIT: begin
          to_cnt      <= to_cnt + 1'b1;
          byte_select <= lane_sel;
          // Timeout outranks both the wait count and a same-edge ext_ack
          if (to_cnt == TO_LAST) begin
            state    <= ST_BERR;
            cpu_berr <= ACTIVE;
          end else if (state == ST_WAIT) begin
            if (wait_cnt != 4'd0) begin
              wait_cnt <= wait_cnt - 4'd1;
            end else if (ext_q) begin
              state <= ST_EXTWAIT;
            end else begin
              state     <= ST_ACK;
              cpu_dsack <= dsack_for_port(port_q);
            end
          end else if (ext_ack == ACTIVE) begin
            state     <= ST_ACK;
            cpu_dsack <= dsack_for_port(port_q);
          end
        end
        ST_ACK, ST_BERR: begin
          // Lanes track DS while a region stays selected; unmapped BERR has none
          byte_select <= (&region_select) ? 4'hF : lane_sel;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_bus_controller.sv
// Directed bench for local_bus_controller: table of bus cycles plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_local_bus_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_as;
  logic        cpu_ds;
  logic [1:0]  cpu_siz;
  logic [31:0] cpu_address;
  logic        ext_ack;
  logic [3:0]  region_select;
  logic [3:0]  byte_select;
  logic [1:0]  cpu_dsack;
  logic        cpu_berr;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  siz;
    logic [3:0]  rs;
    logic [3:0]  bs;
    logic [1:0]  dsack;
    logic        berr;
    int          lat;    // edges after the AS-sampled edge until DSACK/BERR
  } vec_t;

  vec_t vecs[8];

  local_bus_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_as        (cpu_as),
    .cpu_ds        (cpu_ds),
    .cpu_siz       (cpu_siz),
    .cpu_address   (cpu_address),
    .ext_ack       (ext_ack),
    .region_select (region_select),
    .byte_select   (byte_select),
    .cpu_dsack     (cpu_dsack),
    .cpu_berr      (cpu_berr),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {region_select, byte_select, dsack, berr, busy} when fully idle
  task automatic check_idle(input string name);
    check(name, {region_select, byte_select, cpu_dsack, cpu_berr, busy},
          {4'hF, 4'hF, 2'b11, 1'b1, 1'b0});
  endtask

  task automatic run_cycle(input vec_t v, input string tag);
    cpu_address = v.addr;
    cpu_siz     = v.siz;
    cpu_ds      = 1'b0;
    cpu_as      = 1'b0;
    for (int e = 0; e <= v.lat; e++) begin
      step();
      if (e < v.lat) begin
        check({tag, " early"}, {cpu_dsack, cpu_berr}, 3'b111);
      end else begin
        check({tag, " rs"}, region_select, v.rs);
        check({tag, " bs"}, byte_select, v.bs);
        check({tag, " ack"}, {cpu_dsack, cpu_berr}, {v.dsack, v.berr});
        check({tag, " busy"}, busy, 1'b1);
      end
    end
    cpu_as = 1'b1;
    cpu_ds = 1'b1;
    step();
    check_idle({tag, " release"});
  endtask

  initial begin
    logic late_flag;
    //            addr          siz    rs       bs       dsack  berr lat
    vecs[0] = '{32'h0000_0004, 2'b00, 4'b1110, 4'b0000, 2'b00, 1'b1, 3};
    vecs[1] = '{32'h1000_0002, 2'b01, 4'b1101, 4'b1101, 2'b00, 1'b1, 1};
    vecs[2] = '{32'h7000_0000, 2'b01, 4'b1011, 4'b0111, 2'b10, 1'b1, 4};
    vecs[3] = '{32'h4000_0000, 2'b00, 4'b1111, 4'b1111, 2'b11, 1'b0, 0};
    vecs[4] = '{32'h1000_0001, 2'b10, 4'b1101, 4'b1001, 2'b00, 1'b1, 1};
    vecs[5] = '{32'h0000_0003, 2'b11, 4'b1110, 4'b1110, 2'b00, 1'b1, 3};
    vecs[6] = '{32'h1000_0000, 2'b11, 4'b1101, 4'b0001, 2'b00, 1'b1, 1};
    vecs[7] = '{32'h2000_0010, 2'b00, 4'b1111, 4'b1111, 2'b11, 1'b0, 0};

    reset       = 1'b1;
    cpu_as      = 1'b1;
    cpu_ds      = 1'b1;
    cpu_siz     = 2'b00;
    cpu_address = 32'h0;
    ext_ack     = 1'b1;
    step();
    step();
    check_idle("reset state");
    reset = 1'b0;
    step();
    check_idle("idle after reset");

    for (int i = 0; i < 8; i++) run_cycle(vecs[i], $sformatf("vec%0d", i));

    // VME region: ext_ack arrives after 10 cycles in the handshake wait
    cpu_address = 32'h8000_1000;
    cpu_siz     = 2'b00;
    cpu_ds      = 1'b0;
    cpu_as      = 1'b0;
    step();
    check("vme rs", region_select, 4'b0111);
    late_flag = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (cpu_dsack !== 2'b11 || cpu_berr !== 1'b1) late_flag = 1'b1;
    end
    check("vme no early ack", late_flag, 1'b0);
    ext_ack = 1'b0;
    step();
    check("vme dsack", {region_select, byte_select, cpu_dsack, cpu_berr}, {4'b0111, 4'h0, 2'b00, 1'b1});
    ext_ack = 1'b1;
    cpu_as  = 1'b1;
    cpu_ds  = 1'b1;
    step();
    check_idle("vme release");

    // VME timeout, with ext_ack landing on the timeout edge itself
    cpu_as = 1'b0;
    cpu_ds = 1'b0;
    step();
    late_flag = 1'b0;
    for (int e = 1; e <= 254; e++) begin
      step();
      if (cpu_berr !== 1'b1 || cpu_dsack !== 2'b11) late_flag = 1'b1;
    end
    check("timeout not early", late_flag, 1'b0);
    ext_ack = 1'b0;
    step();
    check("timeout berr", {region_select, cpu_dsack, cpu_berr}, {4'b0111, 2'b11, 1'b0});
    ext_ack = 1'b1;
    step();
    check("timeout berr held", {region_select, cpu_dsack, cpu_berr}, {4'b0111, 2'b11, 1'b0});
    cpu_as = 1'b1;
    cpu_ds = 1'b1;
    step();
    check_idle("timeout release");

    // Abort: AS negated mid-WAIT on a ROM cycle
    cpu_address = 32'h0000_0004;
    cpu_as      = 1'b0;
    cpu_ds      = 1'b0;
    step();
    check("abort rs", region_select, 4'b1110);
    step();
    cpu_as = 1'b1;
    cpu_ds = 1'b1;
    step();
    check_idle("abort idle");
    step();
    step();
    check_idle("abort no late ack");
    run_cycle(vecs[1], "after abort");

    // Reset asserted while waiting for ext_ack
    cpu_address = 32'h8000_1000;
    cpu_as      = 1'b0;
    cpu_ds      = 1'b0;
    step();
    step();
    step();
    check("pre-reset busy", {region_select, busy}, {4'b0111, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    check_idle("async reset");
    step();
    cpu_as = 1'b1;
    cpu_ds = 1'b1;
    reset  = 1'b0;
    step();
    check_idle("post reset idle");
    run_cycle(vecs[0], "after reset");

    // DS timing: lanes follow DS while DSACK is held
    cpu_address = 32'h1000_0000;
    cpu_siz     = 2'b00;
    cpu_ds      = 1'b1;
    cpu_as      = 1'b0;
    step();
    check("ds high lanes", {region_select, byte_select}, {4'b1101, 4'hF});
    cpu_ds = 1'b0;
    step();
    check("ds low lanes", {byte_select, cpu_dsack}, {4'h0, 2'b00});
    cpu_ds = 1'b1;
    step();
    check("ds negated in ack", {byte_select, cpu_dsack}, {4'hF, 2'b00});
    cpu_as = 1'b1;
    step();
    check_idle("ds release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
